// File: rtl/uart_in_ep.sv
// uart_in_ep: device-to-host half of the USB-UART bridge.
// Bytes from the local source are queued in a FIFO and served to the USB core on one
// IN endpoint. Reads are speculative until the core finishes the whole packet; a
// partially taken packet is rewound so its bytes are resent in the next packet.
module uart_in_ep #(
  parameter int EP_NUM     = 2,
  parameter int DEPTH_LOG2 = 6,
  parameter int MAX_PKT    = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  wr_dat,
  input  logic        wr_val,
  output logic        wr_rdy,
  input  logic        txact,
  input  logic [3:0]  endpt,
  input  logic        txpop,
  output logic        txval,
  output logic        txcork,
  output logic [7:0]  txdat,
  output logic [11:0] txdat_len
);

  localparam int              PW       = DEPTH_LOG2 + 1;
  localparam int              DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [PW-1:0]   FULL_LVL = PW'(DEPTH);
  localparam logic [11:0]     MAX_LEN  = 12'(MAX_PKT);
  localparam logic [3:0]      MY_EP    = 4'(EP_NUM);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_cmt_q, rd_cmt_d;
  logic [PW-1:0] rd_spec_q, rd_spec_d;
  logic [11:0]   popped_q, popped_d;
  logic [11:0]   len_q, len_d;
  logic [7:0]    txdat_q, txdat_d;
  logic          txcork_q, txcork_d;
  logic          wr_rdy_q, wr_rdy_d;
  logic          txact_q, txact_d;

  logic [7:0]    mem [DEPTH];

  logic [PW-1:0] level, level_next;
  logic [11:0]   level_len;
  logic          wr_en, txact_rise, txval_c;

  // Next-state logic for the FIFO pointers and the IN packet FSM.
  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    level      = wr_ptr_q - rd_cmt_q;
    level_len  = 12'(level);
    wr_en      = wr_val && wr_rdy_q;
    txact_rise = txact && !txact_q;
    txval_c    = (state_q == SEND) && (popped_q < len_q);

    state_d   = state_q;
    wr_ptr_d  = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_cmt_d  = rd_cmt_q;
    rd_spec_d = rd_spec_q;
    popped_d  = popped_q;
    len_d     = len_q;
    txcork_d  = txcork_q;
    txdat_d   = txdat_q;
    txact_d   = txact;

    case (state_q)
      IDLE: begin
        // Cork tracks the level while idle; the value on the txact rise is what
        // stays frozen for the whole packet.
        txcork_d = (level == '0);
        if (txact_rise && endpt == MY_EP) begin
          len_d     = (level_len > MAX_LEN) ? MAX_LEN : level_len;
          rd_spec_d = rd_cmt_q;
          popped_d  = '0;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (txpop && txval_c) begin
          rd_spec_d = rd_spec_q + PW'(1);
          popped_d  = popped_q + 12'd1;
        end
        if (!txact) state_d = DONE;
      end
      DONE: begin
        // Commit only a fully taken packet; otherwise rewind so nothing is lost.
        if (popped_q == len_q) rd_cmt_d  = rd_spec_q;
        else                   rd_spec_d = rd_cmt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Present the byte at the next speculative read address while sending.
    if (state_d == SEND) txdat_d = mem[rd_spec_d[DEPTH_LOG2-1:0]];

    // Ready reflects fullness after this cycle's write and commit, so it never lags.
    level_next = wr_ptr_d - rd_cmt_d;
    wr_rdy_d   = (level_next != FULL_LVL);
  end

  // State registers, asynchronously cleared.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_cmt_q  <= '0;
      rd_spec_q <= '0;
      popped_q  <= '0;
      len_q     <= '0;
      txdat_q   <= '0;
      txcork_q  <= 1'b1;
      wr_rdy_q  <= 1'b1;
      txact_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_cmt_q  <= rd_cmt_d;
      rd_spec_q <= rd_spec_d;
      popped_q  <= popped_d;
      len_q     <= len_d;
      txdat_q   <= txdat_d;
      txcork_q  <= txcork_d;
      wr_rdy_q  <= wr_rdy_d;
      txact_q   <= txact_d;
    end
  end

  // FIFO storage write port.
  // NOTE: the array is not reset; pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_dat;
  end

  assign wr_rdy    = wr_rdy_q;
  assign txval     = txval_c;
  assign txcork    = txcork_q;
  assign txdat     = txdat_q;
  assign txdat_len = len_q;

endmodule

// File: tb/tb_uart_in_ep.sv
// Self-checking bench for uart_in_ep: table-driven IN transactions plus hand-written
// sequences for full/wrap, writes during a packet and reset mid-packet.
module tb_uart_in_ep;

  localparam logic [3:0] EP = 4'd2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  wr_dat;
  logic        wr_val;
  logic        wr_rdy;
  logic        txact;
  logic [3:0]  endpt;
  logic        txpop;
  logic        txval;
  logic        txcork;
  logic [7:0]  txdat;
  logic [11:0] txdat_len;

  uart_in_ep #(.EP_NUM(2), .DEPTH_LOG2(6), .MAX_PKT(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_dat(wr_dat), .wr_val(wr_val), .wr_rdy(wr_rdy),
    .txact(txact), .endpt(endpt), .txpop(txpop),
    .txval(txval), .txcork(txcork), .txdat(txdat), .txdat_len(txdat_len)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Scoreboard: bytes pushed when a write is accepted, popped when a packet commits.
  logic [7:0] model_q[$];

  // Current transaction bookkeeping.
  bit mine;
  int cur_len;
  int cur_popped;
  int last_len = 0;

  typedef struct {
    int         n_wr;
    logic [7:0] base;
    logic [7:0] step;
    logic [3:0] ep;
    int         n_pop;
    int         exp_len;
    bit         exp_cork;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic write_byte(input logic [7:0] d, output bit ok);
    ok     = wr_rdy;
    wr_val = 1'b1;
    wr_dat = d;
    @(negedge clk);
    wr_val = 1'b0;
    if (ok) model_q.push_back(d);
  endtask

  task automatic in_start(input logic [3:0] ep);
    txact = 1'b1;
    endpt = ep;
    mine  = (ep == EP);
    if (mine) begin
      cur_len  = (model_q.size() > 64) ? 64 : model_q.size();
      last_len = cur_len;
    end else begin
      cur_len = last_len;
    end
    cur_popped = 0;
    @(negedge clk);
  endtask

  task automatic in_pops(input int n, input string tag);
    bit exp_v;
    for (int i = 0; i < n; i++) begin
      exp_v = mine && (cur_popped < cur_len);
      check($sformatf("%s txval pop%0d", tag, i), txval, exp_v);
      if (exp_v) check($sformatf("%s txdat pop%0d", tag, i), txdat, model_q[cur_popped]);
      txpop = 1'b1;
      @(negedge clk);
      txpop = 1'b0;
      if (exp_v) cur_popped++;
    end
    check($sformatf("%s txval end", tag), txval, mine && (cur_popped < cur_len));
  endtask

  task automatic in_stop(input string tag);
    txact = 1'b0;
    @(negedge clk);   // DONE
    @(negedge clk);   // IDLE
    if (mine && cur_popped == cur_len)
      for (int i = 0; i < cur_len; i++) void'(model_q.pop_front());
    @(negedge clk);   // cork refreshed from level
    check($sformatf("%s idle cork", tag), txcork, model_q.size() == 0);
    check($sformatf("%s idle txval", tag), txval, 1'b0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int accepted;
    string tag;

    vecs[0] = '{3, 8'h11, 8'h11, 4'd2, 3, 3, 1'b0};  // basic packet
    vecs[1] = '{5, 8'hA0, 8'h01, 4'd2, 2, 5, 1'b0};  // partial take -> rewind
    vecs[2] = '{0, 8'h00, 8'h00, 4'd2, 5, 5, 1'b0};  // resend from A0
    vecs[3] = '{0, 8'h00, 8'h00, 4'd2, 1, 0, 1'b1};  // zero-length packet
    vecs[4] = '{4, 8'h50, 8'h01, 4'd3, 2, 0, 1'b0};  // foreign endpoint ignored
    vecs[5] = '{0, 8'h00, 8'h00, 4'd2, 4, 4, 1'b0};  // data untouched by foreign IN

    rst_n = 1'b0; wr_dat = '0; wr_val = 1'b0; txact = 1'b0; endpt = '0; txpop = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset wr_rdy", wr_rdy, 1'b1);
    check("reset txcork", txcork, 1'b1);
    check("reset txval", txval, 1'b0);
    check("reset txdat_len", txdat_len, 12'd0);

    // Table-driven IN transactions.
    for (int r = 0; r < 6; r++) begin
      tag = $sformatf("row%0d", r);
      for (int k = 0; k < vecs[r].n_wr; k++) begin
        write_byte(vecs[r].base + 8'(k) * vecs[r].step, ok);
        check($sformatf("%s wr_ok%0d", tag, k), ok, 1'b1);
      end
      in_start(vecs[r].ep);
      check($sformatf("%s len", tag), txdat_len, vecs[r].exp_len);
      check($sformatf("%s cork", tag), txcork, vecs[r].exp_cork);
      in_pops(vecs[r].n_pop, tag);
      in_stop(tag);
    end

    // Full FIFO, refused writes, commit-cycle refusal and pointer wrap.
    accepted = 0;
    for (int k = 0; k < 64; k++) begin
      if (k == 63) check("full wr_rdy before 64th", wr_rdy, 1'b1);
      write_byte(8'(k), ok);
      if (ok) accepted++;
    end
    check("full accepted", accepted, 64);
    check("full wr_rdy after 64th", wr_rdy, 1'b0);
    write_byte(8'd64, ok);
    check("full write refused", ok, 1'b0);
    in_start(EP);
    check("full len", txdat_len, 12'd64);
    in_pops(64, "full");
    txact = 1'b0;
    @(negedge clk);   // DONE: commit frees space this cycle
    check("full wr_rdy in commit cycle", wr_rdy, 1'b0);
    write_byte(8'd64, ok);
    check("full write in commit cycle refused", ok, 1'b0);
    for (int i = 0; i < 64; i++) void'(model_q.pop_front());
    check("full wr_rdy after commit", wr_rdy, 1'b1);
    for (int k = 64; k < 70; k++) begin
      write_byte(8'(k), ok);
      check($sformatf("wrap wr_ok%0d", k), ok, 1'b1);
    end
    in_start(EP);
    check("wrap len", txdat_len, 12'd6);
    in_pops(6, "wrap");
    in_stop("wrap");

    // Writes during SEND do not change the snapshot length.
    for (int k = 0; k < 3; k++) write_byte(8'hC0 + 8'(k), ok);
    in_start(EP);
    write_byte(8'hC3, ok);
    write_byte(8'hC4, ok);
    check("send-write len snapshot", txdat_len, 12'd3);
    in_pops(3, "sendwr");
    in_stop("sendwr");
    in_start(EP);
    check("sendwr next len", txdat_len, 12'd2);
    in_pops(2, "sendwr2");
    in_stop("sendwr2");

    // Reset in the middle of a packet discards everything.
    for (int k = 0; k < 4; k++) write_byte(8'hD0 + 8'(k), ok);
    in_start(EP);
    in_pops(1, "rst");
    rst_n = 1'b0;
    txact = 1'b0;
    #1;
    check("midrst wr_rdy", wr_rdy, 1'b1);
    check("midrst txcork", txcork, 1'b1);
    check("midrst txval", txval, 1'b0);
    check("midrst txdat_len", txdat_len, 12'd0);
    check("midrst txdat", txdat, 8'd0);
    model_q.delete();
    last_len = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("postrst cork", txcork, 1'b1);
    in_start(EP);
    check("postrst len", txdat_len, 12'd0);
    check("postrst cork in send", txcork, 1'b1);
    in_pops(1, "postrst");
    in_stop("postrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
